// File: rtl/bio_master.sv
// bio_master: bus initiator that polls board switches/keys and forwards LED writes
module bio_master #(
  parameter int POLL_CYCLES    = 50000,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        stb,
  output logic        we,
  output logic [31:0] data_out,
  input  logic [31:0] data_in,
  input  logic        ack,
  input  logic        wr_req,
  input  logic [7:0]  wr_data,
  output logic        wr_busy,
  output logic [17:0] sw_val,
  output logic [2:0]  keys,
  output logic [2:0]  key_evt,
  output logic        rd_valid,
  output logic        bus_err
);
  localparam int PW = $clog2(POLL_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t        r_state;
  logic [PW-1:0] r_poll_cnt;
  logic          r_poll_due;
  logic [TW-1:0] r_wait;
  logic [7:0]    r_wr_data;
  logic          w_expire;
  logic          w_start_rd;
  logic          w_tmo;
  assign w_expire   = r_poll_cnt == '0;
  assign w_start_rd = r_state == IDLE && !wr_busy && r_poll_due;
  assign w_tmo      = r_state != IDLE && !ack && r_wait == TW'(TIMEOUT_CYCLES - 1);
  // free-running poll timer; a repeated expiry just keeps the single request pending
  always_ff @(posedge clk) begin
    if (rst) begin
      r_poll_cnt <= PW'(POLL_CYCLES - 1);
      r_poll_due <= 1'b1;
    end else begin
      r_poll_cnt <= w_expire ? PW'(POLL_CYCLES - 1) : r_poll_cnt - 1'b1;
      r_poll_due <= w_expire | (r_poll_due & ~w_start_rd);
    end
  end
  // bus FSM with registered strobes, write latch, read decode and ack timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      stb       <= 1'b0;
      we        <= 1'b0;
      data_out  <= '0;
      r_wait    <= '0;
      r_wr_data <= '0;
      wr_busy   <= 1'b0;
      sw_val    <= '0;
      keys      <= '0;
      key_evt   <= '0;
      rd_valid  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      key_evt <= '0;
      if (wr_req && !wr_busy) begin
        r_wr_data <= wr_data;
        wr_busy   <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_wait <= '0;
          if (wr_busy) begin
            r_state  <= WRITE;
            stb      <= 1'b1;
            we       <= 1'b1;
            data_out <= {24'b0, r_wr_data};
          end else if (r_poll_due) begin
            r_state  <= READ;
            stb      <= 1'b1;
            we       <= 1'b0;
            data_out <= '0;
          end
        end
        default: begin
          if (ack || w_tmo) begin
            r_state <= IDLE;
            stb     <= 1'b0;
            we      <= 1'b0;
            if (!ack) bus_err <= 1'b1;
            if (r_state == WRITE) wr_busy <= 1'b0;
            if (r_state == READ && ack) begin
              sw_val   <= {data_in[31:22], data_in[7:0]};
              keys     <= data_in[11:9];
              rd_valid <= 1'b1;
              if (rd_valid) key_evt <= data_in[11:9] & ~keys;
            end
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
      endcase
    end
  end
endmodule
